// File: rtl/viterbi_pkg.sv
// Shared constants, FSM encoding and trellis helpers for the K=3, rate-1/2
// (7,5) hard-decision Viterbi decoder.
package viterbi_pkg;

  localparam int K       = 3;
  localparam int STATE_W = K - 1;
  localparam logic [K-1:0] G0 = 3'o7;
  localparam logic [K-1:0] G1 = 3'o5;
  localparam int PM_INIT = 128;

  typedef enum logic [1:0] {
    ACS   = 2'd0,
    TRACE = 2'd1,
    OUT   = 2'd2
  } state_e;

  // Encoder output for input bit b leaving state s = {b[n-1], b[n-2]}.
  function automatic logic [1:0] expSym(input logic b, input logic [STATE_W-1:0] s);
    logic [K-1:0] r;
    r = {b, s};
    return {^(r & G0), ^(r & G1)};
  endfunction

  function automatic logic [1:0] branchMetric(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[1]} + {1'b0, x[0]};
  endfunction

endpackage

// File: rtl/viterbi_acs4.sv
// Combinational branch metrics and add-compare-select for the four trellis
// states; a tie keeps the predecessor whose low state bit is 0.
module viterbi_acs4
  import viterbi_pkg::*;
#(
  parameter int PM_W = 8
) (
  input  logic [4*PM_W-1:0] pm_i,
  input  logic [1:0]        sym_i,
  output logic [4*PM_W-1:0] pm_o,
  output logic [3:0]        dec_o
);

  always_comb begin
    logic [1:0]      nsv;
    logic [1:0]      p0;
    logic [1:0]      p1;
    logic [PM_W-1:0] s0;
    logic [PM_W-1:0] s1;
    pm_o  = '0;
    dec_o = '0;
    nsv   = '0;
    p0    = '0;
    p1    = '0;
    s0    = '0;
    s1    = '0;
    for (int ns = 0; ns < 4; ns++) begin
      nsv = 2'(ns);
      p0  = {nsv[0], 1'b0};
      p1  = {nsv[0], 1'b1};
      s0  = pm_i[int'(p0)*PM_W +: PM_W] + PM_W'(branchMetric(sym_i, expSym(nsv[1], p0)));
      s1  = pm_i[int'(p1)*PM_W +: PM_W] + PM_W'(branchMetric(sym_i, expSym(nsv[1], p1)));
      if (s1 < s0) begin
        dec_o[ns]               = 1'b1;
        pm_o[ns*PM_W +: PM_W]   = s1;
      end else begin
        pm_o[ns*PM_W +: PM_W]   = s0;
      end
    end
  end

endmodule

// File: rtl/viterbi_decoder_k3.sv
// Frame-based K=3 (7,5) hard-decision Viterbi decoder: ACS per symbol, full
// traceback from state 0 after the tail, then in-order bit streaming.
module viterbi_decoder_k3
  import viterbi_pkg::*;
#(
  parameter int MAX_LEN = 32,
  parameter int PM_W    = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic [1:0]      in_sym,
  input  logic            in_last,
  output logic            in_ready,
  output logic            out_valid,
  output logic            out_bit,
  output logic            out_last,
  input  logic            out_ready,
  output logic [PM_W-1:0] err_count,
  output logic            frame_err
);

  localparam int IDX_W = $clog2(MAX_LEN);
  localparam logic [PM_W-1:0]   PM_INIT_W     = PM_W'(PM_INIT);
  localparam logic [4*PM_W-1:0] PM_FRAME_INIT = {{3{PM_INIT_W}}, {PM_W{1'b0}}};

  state_e            state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic [IDX_W-1:0]  tIdx_q;
  logic [IDX_W-1:0]  oIdx_q;
  logic [IDX_W-1:0]  lastIdx_q;
  logic [1:0]        tState_q;
  logic [4*PM_W-1:0] pm_q;
  logic [4*PM_W-1:0] pm_d;
  logic [3:0]        dec_d;
  logic [3:0]        surv_q [MAX_LEN];
  logic [MAX_LEN-1:0] bitbuf_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic              out_bit_q;
  logic              out_last_q;
  logic              frame_err_q;
  logic [PM_W-1:0]   err_count_q;
  logic              accept;
  logic              lastSym;
  logic              survBit;
  logic [IDX_W-1:0]  nextOIdx;

  viterbi_acs4 #(.PM_W(PM_W)) u_acs (
    .pm_i  (pm_q),
    .sym_i (in_sym),
    .pm_o  (pm_d),
    .dec_o (dec_d)
  );

  assign accept   = in_valid && in_ready_q;
  assign lastSym  = in_last || (cnt_q == IDX_W'(MAX_LEN - 1));
  assign survBit  = surv_q[tIdx_q][tState_q];
  assign nextOIdx = oIdx_q + IDX_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACS;
      cnt_q       <= '0;
      pm_q        <= PM_FRAME_INIT;
      tIdx_q      <= '0;
      tState_q    <= '0;
      oIdx_q      <= '0;
      lastIdx_q   <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_bit_q   <= 1'b0;
      out_last_q  <= 1'b0;
      err_count_q <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        ACS: begin
          if (accept) begin
            if (lastSym && (cnt_q < IDX_W'(2))) begin
              frame_err_q <= 1'b1;
              pm_q        <= PM_FRAME_INIT;
              cnt_q       <= '0;
            end else if (lastSym) begin
              pm_q        <= pm_d;
              err_count_q <= pm_d[PM_W-1:0];
              state_q     <= TRACE;
              in_ready_q  <= 1'b0;
              tIdx_q      <= cnt_q;
              tState_q    <= '0;
              lastIdx_q   <= cnt_q - IDX_W'(2);
            end else begin
              pm_q  <= pm_d;
              cnt_q <= cnt_q + IDX_W'(1);
            end
          end
        end
        // Walk back one stage per cycle; bit 0 goes straight to the output register.
        TRACE: begin
          tState_q <= {tState_q[0], survBit};
          if (tIdx_q == '0) begin
            state_q     <= OUT;
            out_valid_q <= 1'b1;
            out_bit_q   <= tState_q[1];
            out_last_q  <= (lastIdx_q == '0);
            oIdx_q      <= '0;
          end else begin
            tIdx_q <= tIdx_q - IDX_W'(1);
          end
        end
        OUT: begin
          if (out_valid_q && out_ready) begin
            if (out_last_q) begin
              state_q     <= ACS;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_bit_q   <= 1'b0;
              out_last_q  <= 1'b0;
              pm_q        <= PM_FRAME_INIT;
              cnt_q       <= '0;
            end else begin
              oIdx_q     <= nextOIdx;
              out_bit_q  <= bitbuf_q[nextOIdx];
              out_last_q <= (nextOIdx == lastIdx_q);
            end
          end
        end
        default: state_q <= ACS;
      endcase
    end
  end

  // Survivor and bit storage need no reset: every entry is written before use.
  always_ff @(posedge clk) begin
    if (accept) surv_q[cnt_q] <= dec_d;
    if (state_q == TRACE) bitbuf_q[tIdx_q] <= tState_q[1];
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_bit   = out_bit_q;
  assign out_last  = out_last_q;
  assign err_count = err_count_q;
  assign frame_err = frame_err_q;

endmodule

// File: tb/tb_viterbi_decoder_k3.sv
// Self-checking bench: reference encoder with injected bit flips predicts the
// decoded bits, err_count (flip count) and handshake timing.
module tb_viterbi_decoder_k3;

  localparam int MAX_LEN = 32;
  localparam int PM_W    = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic [1:0]      in_sym;
  logic            in_last;
  logic            in_ready;
  logic            out_valid;
  logic            out_bit;
  logic            out_last;
  logic            out_ready;
  logic [PM_W-1:0] err_count;
  logic            frame_err;

  int errors = 0;
  int checks = 0;

  logic [1:0] txSym[$];
  bit         txBits[$];

  always #5 clk = ~clk;

  viterbi_decoder_k3 #(.MAX_LEN(MAX_LEN), .PM_W(PM_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_sym    (in_sym),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_bit   (out_bit),
    .out_last  (out_last),
    .out_ready (out_ready),
    .err_count (err_count),
    .frame_err (frame_err)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference encoder: data bits plus two zero tail bits, then distinct bit flips.
  task automatic buildFrame(input int nData, input int flips);
    bit p1, p2, b;
    int pos;
    logic [1:0] tmp;
    bit used[int];
    txBits.delete();
    txSym.delete();
    p1 = 0;
    p2 = 0;
    for (int i = 0; i < nData + 2; i++) begin
      b = (i < nData) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i < nData) txBits.push_back(b);
      txSym.push_back({b ^ p1 ^ p2, b ^ p2});
      p2 = p1;
      p1 = b;
    end
    for (int f = 0; f < flips; f++) begin
      do pos = $urandom_range(0, 2 * (nData + 2) - 1); while (used.exists(pos));
      used[pos] = 1'b1;
      tmp = txSym[pos / 2];
      tmp[pos % 2] = ~tmp[pos % 2];
      txSym[pos / 2] = tmp;
    end
  endtask

  task automatic applyStimulus(input bit useLast, input bit gaps);
    bit rdy;
    int guard;
    for (int i = 0; i < txSym.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_sym   = txSym[i];
      in_last  = useLast && (i == txSym.size() - 1);
      guard    = 0;
      rdy      = 1'b0;
      while (!rdy && guard < 200) begin
        @(negedge clk);
        rdy = in_ready;
        @(posedge clk);
        #1;
        guard++;
      end
      if (!rdy) begin
        checkOutput("in_ready_timeout", 0, 1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collectFrame(input bit toggleReady, input logic [PM_W-1:0] expErr);
    int lat = 0;
    int k = 0;
    int guard = 0;
    int n;
    bit stalled = 0;
    logic pb = 1'b0;
    logic pl = 1'b0;
    n = txBits.size();
    checkOutput("in_ready_busy", in_ready, 0);
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("latency", lat, n + 2);
    while (k < n && guard < 400) begin
      out_ready = toggleReady ? (guard % 2 == 1) : 1'b1;
      @(negedge clk);
      if (stalled) begin
        checkOutput("hold_bit", out_bit, pb);
        checkOutput("hold_last", out_last, pl);
      end
      if (out_valid) begin
        checkOutput("in_ready_out", in_ready, 0);
        if (out_ready) begin
          checkOutput("bit", out_bit, txBits[k]);
          checkOutput("last", out_last, (k == n - 1));
          k++;
          stalled = 0;
        end else begin
          stalled = 1;
          pb = out_bit;
          pl = out_last;
        end
      end else begin
        checkOutput("valid_gap", out_valid, 1);
        stalled = 0;
      end
      @(posedge clk);
      #1;
      guard++;
    end
    if (k < n) checkOutput("out_timeout", k, n);
    out_ready = 1'b1;
    checkOutput("out_valid_done", out_valid, 0);
    checkOutput("in_ready_done", in_ready, 1);
    checkOutput("err_count", err_count, expErr);
  endtask

  task automatic loadCleanFrame();
    txSym  = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    txBits = '{1, 0, 1, 1};
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    int nData;
    int flips;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_sym    = 2'b00;
    in_last   = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_bit", out_bit, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_err_count", err_count, 0);
    checkOutput("rst_frame_err", frame_err, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] clean frame");
    loadCleanFrame();
    applyStimulus(1, 0);
    collectFrame(0, 0);

    $display("[TB] single corrected error");
    loadCleanFrame();
    txSym[2] = 2'b10;
    applyStimulus(1, 0);
    collectFrame(0, 1);

    $display("[TB] reset mid-frame");
    loadCleanFrame();
    txSym = txSym[0:2];
    applyStimulus(0, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_in_ready", in_ready, 1);
    checkOutput("mid_rst_out_valid", out_valid, 0);
    checkOutput("mid_rst_out_bit", out_bit, 0);
    checkOutput("mid_rst_out_last", out_last, 0);
    checkOutput("mid_rst_err_count", err_count, 0);
    checkOutput("mid_rst_frame_err", frame_err, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("post_rst_out_valid", out_valid, 0);
    loadCleanFrame();
    applyStimulus(1, 0);
    collectFrame(0, 0);

    $display("[TB] backpressure");
    loadCleanFrame();
    applyStimulus(1, 0);
    collectFrame(1, 0);

    $display("[TB] short frame");
    txSym = '{2'b11, 2'b10};
    applyStimulus(1, 0);
    checkOutput("frame_err_pulse", frame_err, 1);
    checkOutput("short_in_ready", in_ready, 1);
    seen = 0;
    @(posedge clk);
    #1;
    checkOutput("frame_err_clear", frame_err, 0);
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen++;
      @(posedge clk);
      #1;
    end
    checkOutput("short_no_output", seen, 0);
    loadCleanFrame();
    applyStimulus(1, 0);
    collectFrame(0, 0);

    $display("[TB] forced-last frame");
    buildFrame(MAX_LEN - 2, 0);
    applyStimulus(0, 1);
    collectFrame(0, 0);

    $display("[TB] random frames");
    for (int r = 0; r < 10; r++) begin
      nData = $urandom_range(1, MAX_LEN - 2);
      flips = $urandom_range(0, 2);
      buildFrame(nData, flips);
      applyStimulus(1, 1);
      collectFrame(1'($urandom_range(0, 1)), PM_W'(flips));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
